// File: rtl/cpu24_data_mem_responder.sv
// Slave end of the 24-bit CPU load/store handshake: captures one request, waits
// WAIT_STATES cycles, accesses on-chip RAM and returns a one-cycle Ack.
// Optional access statistics are compiled in with `define DMEM_STATS_EN.
module cpu24_data_mem_responder #(
    parameter int DATA_W      = 24,
    parameter int ADDR_W      = 24,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Req,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic              Ack,
    output logic [DATA_W-1:0] RData,
    output logic              Err,
    output logic              Busy,
`ifdef DMEM_STATS_EN
    output logic [15:0]       RdCount,
    output logic [15:0]       WrCount,
    output logic [7:0]        ErrCount,
`endif
    output logic [1:0]        DbgState
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              mem_we;

    // Only the low index bits address the RAM; the full address decides range.
    assign in_range = (addr_q < ADDR_W'(DEPTH));
    assign idx      = addr_q[IDX_W-1:0];
    assign mem_we   = (state_q == S_ACCESS) && we_q && in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = ack_q;
        err_d   = err_q;
        busy_d  = busy_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    we_d    = WrEn;
                    addr_d  = Addr;
                    wdata_d = WData;
                    cnt_d   = 4'(WAIT_STATES);
                    busy_d  = 1'b1;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ack_d   = 1'b1;
                err_d   = !in_range;
                rdata_d = (we_q || !in_range) ? '0 : mem_q[idx];
                state_d = S_RESP;
            end
            S_RESP: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM contents survive reset; a reset forces IDLE so no pending store lands.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;
    logic [7:0]  err_cnt_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (state_q == S_ACCESS) begin
            if (!in_range) begin
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end else if (we_q) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign RdCount  = rd_cnt_q;
    assign WrCount  = wr_cnt_q;
    assign ErrCount = err_cnt_q;
`endif

    assign Ack      = ack_q;
    assign RData    = rdata_q;
    assign Err      = err_q;
    assign Busy     = busy_q;
    assign DbgState = state_q;

endmodule

// File: tb/tb_cpu24_data_mem_responder.sv
// Bench for cpu24_data_mem_responder: two instances (2 and 0 wait states) share
// the stimulus; a timestamp-based transaction model predicts every output.
module tb_cpu24_data_mem_responder;

    localparam int W2 = 2;
    localparam int W0 = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wr_en = 1'b0;
    logic [23:0] addr = '0;
    logic [23:0] wdata = '0;

    logic        ack_w2, err_w2, busy_w2;
    logic        ack_w0, err_w0, busy_w0;
    logic [23:0] rdata_w2, rdata_w0;
    logic [1:0]  dbg_w2, dbg_w0;
`ifdef DMEM_STATS_EN
    logic [15:0] rdc_w2, wrc_w2, rdc_w0, wrc_w0;
    logic [7:0]  erc_w2, erc_w0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    int ack2_q[$];
    int ack0_q[$];
    bit err2_q[$];
    bit err0_q[$];

    always #5 clk = ~clk;

    cpu24_data_mem_responder #(.DATA_W(24), .ADDR_W(24), .DEPTH(256), .WAIT_STATES(W2)) u_dut_w2 (
        .Clock(clk), .Reset_n(rst_n), .Req(req), .WrEn(wr_en), .Addr(addr), .WData(wdata),
        .Ack(ack_w2), .RData(rdata_w2), .Err(err_w2), .Busy(busy_w2),
`ifdef DMEM_STATS_EN
        .RdCount(rdc_w2), .WrCount(wrc_w2), .ErrCount(erc_w2),
`endif
        .DbgState(dbg_w2)
    );

    cpu24_data_mem_responder #(.DATA_W(24), .ADDR_W(24), .DEPTH(256), .WAIT_STATES(W0)) u_dut_w0 (
        .Clock(clk), .Reset_n(rst_n), .Req(req), .WrEn(wr_en), .Addr(addr), .WData(wdata),
        .Ack(ack_w0), .RData(rdata_w0), .Err(err_w0), .Busy(busy_w0),
`ifdef DMEM_STATS_EN
        .RdCount(rdc_w0), .WrCount(wrc_w0), .ErrCount(erc_w0),
`endif
        .DbgState(dbg_w0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ws_of(input int i);
        return (i == 0) ? W2 : W0;
    endfunction

    // Model: a request captured at edge c is answered at edge c+W+1 (Ack seen for
    // one cycle), the responder is free again after edge c+W+2.
    bit          m_pend [2];
    int          m_cap [2];
    bit          m_we [2];
    logic [23:0] m_addr [2];
    logic [23:0] m_wd [2];
    bit          m_ack [2];
    bit          m_err [2];
    bit          m_busy [2];
    logic [23:0] m_rdata [2];
    bit          m_rd_known [2] = '{1'b1, 1'b1};
    logic [23:0] m_mem [2][256];
    bit          m_known [2][256];

    always @(posedge clk) begin : model
        bit was_pend;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_pend[i]     = 1'b0;
                m_ack[i]      = 1'b0;
                m_err[i]      = 1'b0;
                m_busy[i]     = 1'b0;
                m_rdata[i]    = '0;
                m_rd_known[i] = 1'b1;
            end else begin
                was_pend = m_pend[i];
                m_ack[i] = 1'b0;
                m_err[i] = 1'b0;
                if (m_pend[i] && cyc == m_cap[i] + ws_of(i) + 1) begin
                    m_ack[i] = 1'b1;
                    if (m_addr[i] >= 24'd256) begin
                        m_err[i]      = 1'b1;
                        m_rdata[i]    = '0;
                        m_rd_known[i] = 1'b1;
                    end else if (m_we[i]) begin
                        m_mem[i][m_addr[i][7:0]]   = m_wd[i];
                        m_known[i][m_addr[i][7:0]] = 1'b1;
                        m_rdata[i]    = '0;
                        m_rd_known[i] = 1'b1;
                    end else begin
                        m_rdata[i]    = m_mem[i][m_addr[i][7:0]];
                        m_rd_known[i] = m_known[i][m_addr[i][7:0]];
                    end
                end
                if (m_pend[i] && cyc == m_cap[i] + ws_of(i) + 2) begin
                    m_pend[i] = 1'b0;
                end
                if (!was_pend && req) begin
                    m_pend[i] = 1'b1;
                    m_cap[i]  = cyc;
                    m_we[i]   = wr_en;
                    m_addr[i] = addr;
                    m_wd[i]   = wdata;
                end
                m_busy[i] = m_pend[i];
            end
        end
    end

    // Compare every cycle; Ack timestamps are the edge that samples the pulse.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("w2_ack", {31'd0, ack_w2}, {31'd0, m_ack[0]});
            chk("w2_busy", {31'd0, busy_w2}, {31'd0, m_busy[0]});
            chk("w2_err", {31'd0, err_w2}, {31'd0, m_err[0]});
            if (m_rd_known[0]) chk("w2_rdata", {8'd0, rdata_w2}, {8'd0, m_rdata[0]});
            chk("w0_ack", {31'd0, ack_w0}, {31'd0, m_ack[1]});
            chk("w0_busy", {31'd0, busy_w0}, {31'd0, m_busy[1]});
            chk("w0_err", {31'd0, err_w0}, {31'd0, m_err[1]});
            if (m_rd_known[1]) chk("w0_rdata", {8'd0, rdata_w0}, {8'd0, m_rdata[1]});
            if (ack_w2 === 1'b1) begin
                ack2_q.push_back(cyc + 1);
                err2_q.push_back(err_w2);
            end
            if (ack_w0 === 1'b1) begin
                ack0_q.push_back(cyc + 1);
                err0_q.push_back(err_w0);
            end
        end
    end

    // Called right after a negedge; Req is high for `hold` capture edges.
    task automatic txn(input bit we_in, input logic [23:0] a, input logic [23:0] d,
                       input int hold, output int cap);
        int n;
        req   = 1'b1;
        wr_en = we_in;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1 cap = cyc;
        for (int k = 1; k < hold; k++) @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while ((busy_w2 || busy_w0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("busy_timeout", 32'(n), 32'd0);
        @(negedge clk);
    endtask

    // One transaction: one Ack per instance at capture+W+2.
    task automatic chk_single(input string name, input int s2, input int s0, input int cap);
        chk({name, "_n_ack_w2"}, 32'(ack2_q.size()), 32'(s2 + 1));
        chk({name, "_n_ack_w0"}, 32'(ack0_q.size()), 32'(s0 + 1));
        if (ack2_q.size() > s2) chk({name, "_lat_w2"}, 32'(ack2_q[s2] - cap), 32'd4);
        if (ack0_q.size() > s0) chk({name, "_lat_w0"}, 32'(ack0_q[s0] - cap), 32'd2);
    endtask

    initial begin : stim
        int cap, s2, s0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {31'd0, ack_w2}, 32'd0);
        chk("rst_busy", {31'd0, busy_w2}, 32'd0);
        chk("rst_err", {31'd0, err_w0}, 32'd0);
        chk("rst_rdata", {8'd0, rdata_w0}, 32'd0);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_no_ack", 32'(ack2_q.size() + ack0_q.size()), 32'd0);

        s2 = ack2_q.size(); s0 = ack0_q.size();
        txn(1'b1, 24'h000010, 24'hA5C3F0, 1, cap);
        chk_single("st10", s2, s0, cap);
        if (err2_q.size() > 0) chk("st10_err", {31'd0, err2_q[err2_q.size()-1]}, 32'd0);

        s2 = ack2_q.size(); s0 = ack0_q.size();
        txn(1'b0, 24'h000010, 24'h0, 1, cap);
        chk_single("ld10", s2, s0, cap);
        chk("ld10_rdata_w2", {8'd0, rdata_w2}, 32'hA5C3F0);
        chk("ld10_rdata_w0", {8'd0, rdata_w0}, 32'hA5C3F0);

        txn(1'b1, 24'h000005, 24'h123456, 1, cap);
        chk("st5_rdata_cleared", {8'd0, rdata_w0}, 32'd0);
        s2 = ack2_q.size(); s0 = ack0_q.size();
        txn(1'b0, 24'h000005, 24'h0, 1, cap);
        chk_single("ld5", s2, s0, cap);
        chk("ld5_rdata_w0", {8'd0, rdata_w0}, 32'h123456);

        txn(1'b1, 24'h000000, 24'h5A5A5A, 1, cap);
        txn(1'b1, 24'h000100, 24'hFFFFFF, 1, cap);
        if (err2_q.size() > 0) chk("oor_st_err_w2", {31'd0, err2_q[err2_q.size()-1]}, 32'd1);
        if (err0_q.size() > 0) chk("oor_st_err_w0", {31'd0, err0_q[err0_q.size()-1]}, 32'd1);
        txn(1'b0, 24'h000000, 24'h0, 1, cap);
        chk("oor_addr0_kept", {8'd0, rdata_w2}, 32'h5A5A5A);
        txn(1'b0, 24'h0123FF, 24'h0, 1, cap);
        chk("oor_ld_rdata", {8'd0, rdata_w2}, 32'd0);

        txn(1'b1, 24'h0000FF, 24'hABCDEF, 1, cap);
        txn(1'b0, 24'h0000FF, 24'h0, 1, cap);
        chk("top_addr_rdata", {8'd0, rdata_w0}, 32'hABCDEF);

        s2 = ack2_q.size(); s0 = ack0_q.size();
        txn(1'b0, 24'h000010, 24'h0, 2, cap);
        chk_single("drop", s2, s0, cap);

        s2 = ack2_q.size(); s0 = ack0_q.size();
        txn(1'b0, 24'h000005, 24'h0, 6, cap);
        chk("held_n_ack_w2", 32'(ack2_q.size()), 32'(s2 + 2));
        chk("held_n_ack_w0", 32'(ack0_q.size()), 32'(s0 + 2));
        if (ack2_q.size() > s2 + 1) chk("held_gap_w2", 32'(ack2_q[s2+1] - ack2_q[s2]), 32'd5);
        if (ack0_q.size() > s0 + 1) chk("held_gap_w0", 32'(ack0_q[s0+1] - ack0_q[s0]), 32'd3);

        txn(1'b1, 24'h000007, 24'h777777, 1, cap);
        s2 = ack2_q.size(); s0 = ack0_q.size();
        req = 1'b1; wr_en = 1'b1; addr = 24'h000007; wdata = 24'h0F0F0F;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rstmid_no_ack", 32'(ack2_q.size() + ack0_q.size()), 32'(s2 + s0));
        txn(1'b0, 24'h000007, 24'h0, 1, cap);
        chk("rstmid_old_w2", {8'd0, rdata_w2}, 32'h777777);
        chk("rstmid_old_w0", {8'd0, rdata_w0}, 32'h777777);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
        $fatal(1, "watchdog expired");
    end

endmodule
